// File: rtl/alu_iter.sv
// alu_iter: handshaked ALU with iterative one-bit-per-cycle shifts; define ALU_ITER_FAST_SHIFT_EN for a single-cycle barrel shifter
module alu_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;
  logic [3:0] op;
  logic [WIDTH-1:0] work, alu, res;
  logic [4:0] cnt, amt;
  logic long_shift;
  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] o, input logic [WIDTH-1:0] v);
    return o == 4'd7 ? {v[WIDTH-2:0], 1'b0} : {o == 4'd9 && v[WIDTH-1], v[WIDTH-1:1]};
  endfunction
  assign amt = SrcB[4:0];
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  always_comb begin
    alu = '0;
    case (ALUControl)
      4'd0: alu = SrcA + SrcB;
      4'd1: alu = SrcA - SrcB;
      4'd2: alu = SrcA & SrcB;
      4'd3: alu = SrcA | SrcB;
      4'd4: alu = SrcA ^ SrcB;
      4'd5: alu = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      4'd6: alu = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
`ifdef ALU_ITER_FAST_SHIFT_EN
      4'd7: alu = SrcA << amt;
      4'd8: alu = SrcA >> amt;
      4'd9: alu = $signed(SrcA) >>> amt;
`else
      4'd7, 4'd8, 4'd9: alu = SrcA;
`endif
      default: alu = '0;
    endcase
  end
`ifdef ALU_ITER_FAST_SHIFT_EN
  assign long_shift = 1'b0;
  assign res = alu;
`else
  logic is_shift;
  assign is_shift = ALUControl inside {4'd7, 4'd8, 4'd9};
  assign long_shift = is_shift && amt > 5'd1;
  // the accept edge performs the first shift, so latency equals the shift amount
  assign res = is_shift && amt == 5'd1 ? shift1(ALUControl, SrcA) : alu;
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      work <= '0;
      cnt <= '0;
      ALUResult <= '0;
      Zero <= 1'b1;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          op <= ALUControl;
          if (long_shift) begin
            work <= shift1(ALUControl, SrcA);
            cnt <= amt - 5'd1;
            state <= SHIFT;
          end else begin
            ALUResult <= res;
            Zero <= res == '0;
            state <= DONE;
          end
        end
        SHIFT: begin
          work <= shift1(op, work);
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            ALUResult <= shift1(op, work);
            Zero <= shift1(op, work) == '0;
            state <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: scoreboard bench for alu_iter with a reference model and latency checking
module tb_alu_iter;
  logic clk = 0, reset = 1, in_valid = 0, in_ready, out_valid, out_ready = 1, Zero;
  logic [3:0] ALUControl = '0;
  logic [31:0] SrcA = '0, SrcB = '0, ALUResult;
  int checks = 0, fails = 0, cyc = 0;
  logic rr_mode = 0, rr_fixed = 1;
  typedef struct {logic [31:0] res; int lat; int acc;} exp_t;
  exp_t q[$];

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB),
    .out_valid(out_valid), .out_ready(out_ready), .ALUResult(ALUResult), .Zero(Zero));

  always #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end
  initial forever begin
    @(posedge clk); #1;
    out_ready = rr_mode ? 1'($urandom_range(0, 1)) : rr_fixed;
  end
  initial begin #2000000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int latency(input logic [3:0] op, input logic [31:0] b);
`ifdef ALU_ITER_FAST_SHIFT_EN
    return 1;
`else
    return (op >= 4'd7 && op <= 4'd9 && b[4:0] != 0) ? int'(b[4:0]) : 1;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1; ALUControl = op; SrcA = a; SrcB = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      if (++n > 200) break;
    end
    if (!in_ready) begin
      checks++; fails++;
      $display("FAIL accept_timeout: got in_ready 0 expected 1 within 200 cycles");
    end else q.push_back('{model(op, a, b), latency(op, b), cyc});
    @(posedge clk); #1;
    in_valid = 0; SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
  endtask

  // monitor: checks every presented result against the scoreboard head
  initial begin
    bit seen = 0, popped = 0;
    forever begin
      @(negedge clk);
      if (reset) begin seen = 0; popped = 0; end
      else begin
        if (popped) begin
          chk("idle_after_pop_valid", 32'(out_valid), 32'd0);
          chk("idle_after_pop_ready", 32'(in_ready), 32'd1);
          popped = 0;
        end
        if (out_valid) begin
          chk("in_ready_while_valid", 32'(in_ready), 32'd0);
          if (q.size() == 0) begin
            checks++; fails++;
            $display("FAIL unexpected_result: got %h expected no output", ALUResult);
          end else begin
            chk("result", ALUResult, q[0].res);
            chk("zero", 32'(Zero), 32'(q[0].res == 0));
            if (!seen) chk("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
            seen = !out_ready;
            if (out_ready) begin void'(q.pop_front()); popped = 1; end
          end
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] a, b;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", ALUResult, 32'd0);
    chk("reset_zero", 32'(Zero), 32'd1);
    reset = 0;
    @(negedge clk);
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    issue(4'd0, 32'h7FFFFFFF, 32'h1);
    issue(4'd1, 32'd5, 32'd5);
    issue(4'd1, 32'd0, 32'd1);
    issue(4'd5, 32'h80000000, 32'd0);
    issue(4'd6, 32'h80000000, 32'd0);
    issue(4'd9, 32'h80000000, 32'd31);
    issue(4'd7, 32'h1, 32'h20);
    issue(4'd8, 32'hF0, 32'd4);
    issue(4'd11, 32'hDEAD, 32'hBEEF);
    // hold a result under back-pressure
    rr_fixed = 0;
    issue(4'd0, 32'h10, 32'h2);
    repeat (6) @(posedge clk);
    #1 rr_fixed = 1;
    repeat (3) @(posedge clk);
    #1;
    // reset mid-shift aborts the operation
    issue(4'd7, 32'h1, 32'd20);
    repeat (6) @(posedge clk);
    #1 reset = 1;
    q.delete();
    @(posedge clk); #1 reset = 0;
    @(negedge clk);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", ALUResult, 32'd0);
    chk("abort_zero", 32'(Zero), 32'd1);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    // randomized traffic with random back-pressure
    rr_mode = 1;
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'h80000000 >> $urandom_range(0, 1) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      issue(4'($urandom_range(0, 15)), a, b);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    n = 0;
    while (q.size() > 0 && n < 5000) begin @(negedge clk); n++; end
    if (q.size() > 0) begin
      checks++; fails++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/alu_iter.md
ALU_ITER -- requirements
Module: alu_iter

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width; legal value 32 only; shift amount is SrcB[4:0].
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 in_valid  input  1  operation request valid.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 ALUControl  input  4  op code: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
REQ-007 SrcA  input  WIDTH  operand A.
REQ-008 SrcB  input  WIDTH  operand B / shift amount.
REQ-009 out_valid  output  1  ALUResult/Zero valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 ALUResult  output  WIDTH  registered result.
REQ-012 Zero  output  1  high when ALUResult == 0, registered alongside ALUResult.

Function
REQ-013 FSM states IDLE, SHIFT, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 Accept = in_valid & in_ready; ALUControl, SrcA, SrcB captured on accept; inputs ignored otherwise.
REQ-015 IDLE, accept, non-shift op: result computed and registered, next state DONE (out_valid one cycle after accept).
REQ-016 IDLE, accept, shift op with SrcB[4:0] == 0: ALUResult = SrcA, next state DONE.
REQ-017 IDLE, accept, shift op with SrcB[4:0] = N > 0: load SrcA into working register and N into 5-bit counter, next state SHIFT.
REQ-018 SHIFT: each cycle shift working register one bit (SLL: zero fill at LSB; SRL: zero fill at MSB; SRA: replicate bit WIDTH-1), decrement counter; on the cycle counter goes 1 -> 0, next state DONE; total latency accept-to-out_valid = N cycles.
REQ-019 DONE: ALUResult and Zero held stable while out_valid & !out_ready; on out_ready, next state IDLE; no new operation accepted in the same cycle.
REQ-020 ADD/SUB: modulo 2^WIDTH, carry/overflow discarded; AND/OR/XOR bitwise.
REQ-021 SLT: 1 if SrcA < SrcB two's-complement signed, else 0, zero-extended; SLTU: same, unsigned.
REQ-022 Codes 1010-1111: ALUResult = 0, Zero = 1, single-cycle path as REQ-015.
REQ-023 Boundaries: 0x7FFFFFFF + 1 = 0x80000000; 0 - 1 = 0xFFFFFFFF; SLT(0x80000000, 0) = 1; SLTU(0x80000000, 0) = 0; SRA 31 of 0x80000000 = 0xFFFFFFFF.
REQ-024 in_valid held high across a busy period: request accepted on the first IDLE cycle only; one result per accept, order preserved.

Reset
REQ-025 reset high at a clock edge: state IDLE, out_valid 0, ALUResult 0, Zero 1, shift counter 0, working register 0; in_ready 1 the cycle after reset deasserts.
REQ-026 reset during SHIFT or DONE aborts the operation; no out_valid for it is ever produced.
REQ-027 reset has priority over accept and over out_ready in the same cycle.

Configuration
REQ-028 Macro ALU_ITER_FAST_SHIFT_EN defined: shifts use single-cycle barrel shifter, follow REQ-015 path (latency 1), SHIFT state never entered.
REQ-029 Macro undefined: iterative shift per REQ-016 to REQ-018; results bit-identical to the defined case, only latency differs.

Verification
REQ-030 Reset, then ADD 0x7FFFFFFF + 0x00000001, out_ready=1 -> out_valid next cycle, ALUResult 0x80000000, Zero 0, in_ready back to 1 the following cycle.
REQ-031 SUB 5 - 5 -> ALUResult 0, Zero 1; SLT 0x80000000,0 -> 1; SLTU 0x80000000,0 -> 0.
REQ-032 SRA SrcA=0x80000000, SrcB=31, macro undefined -> out_valid exactly 31 cycles after accept, ALUResult 0xFFFFFFFF; macro defined -> 1 cycle.
REQ-033 SLL SrcA=0x1, SrcB=0x20 (amount 0) -> ALUResult 0x1 after 1 cycle; SRL 0xF0 by 4 -> 0x0F after 4 cycles.
REQ-034 Result 0x12 with out_ready=0 for 5 cycles -> out_valid and ALUResult stable 5 cycles, in_ready 0; out_ready=1 -> IDLE next cycle.
REQ-035 Reset asserted mid-SHIFT (SLL by 20, cycle 7) -> next cycle IDLE, out_valid 0, ALUResult 0, no result emitted for the aborted op.
